// File: rtl/vip_pkg.sv
// Shared definitions for the Avalon-ST Video test pattern source:
// packet types, FSM states, pattern codes and the control-packet nibble map.
package vip_pkg;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    CTRL_HDR,
    CTRL_NIB,
    VID_HDR,
    VID_PIX
  } state_e;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FLAT  = 2'd3;

  // Control packet payload: width and height most-significant nibble first,
  // then the interlace nibble in the ninth (last) slot.
  function automatic logic [3:0] ctrl_nibble(input logic [15:0] width,
                                             input logic [15:0] height,
                                             input logic [3:0]  interlaced,
                                             input logic [3:0]  idx);
    case (idx)
      4'd0:    ctrl_nibble = width[15:12];
      4'd1:    ctrl_nibble = width[11:8];
      4'd2:    ctrl_nibble = width[7:4];
      4'd3:    ctrl_nibble = width[3:0];
      4'd4:    ctrl_nibble = height[15:12];
      4'd5:    ctrl_nibble = height[11:8];
      4'd6:    ctrl_nibble = height[7:4];
      4'd7:    ctrl_nibble = height[3:0];
      default: ctrl_nibble = interlaced;
    endcase
  endfunction

endpackage

// File: rtl/vip_pattern_pixel_gen.sv
// Combinational pixel generator: maps (pattern, x, y, frame_count) to an
// 8-bit greyscale value.
module vip_pattern_pixel_gen
  import vip_pkg::*;
#(
  parameter int CHECKER_SHIFT = 3
) (
  input  logic [1:0]  pattern,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [7:0]  frame_count,
  output logic [7:0]  pixel
);

  always_comb begin
    pixel = 8'h00;
    case (pattern)
      PAT_HRAMP: pixel = x[7:0];
      PAT_VRAMP: pixel = y[7:0];
      PAT_CHECK: begin
        // Square parity: low bit of the XOR of the square coordinates.
        if ((((x >> CHECKER_SHIFT) ^ (y >> CHECKER_SHIFT)) & 16'd1) != 16'd0) begin
          pixel = 8'hFF;
        end
      end
      PAT_FLAT:  pixel = frame_count;
      default:   pixel = 8'h00;
    endcase
  end

endmodule

// File: rtl/vip_test_pattern_source.sv
// Avalon-ST Video transmitter producing control + video packet frames with a
// selectable synthetic pattern; geometry is latched at every frame start.
module vip_test_pattern_source
  import vip_pkg::*;
#(
  parameter int BITS_PER_SYMBOL = 8,
  parameter int CHECKER_SHIFT   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [15:0]                cfg_width,
  input  logic [15:0]                cfg_height,
  input  logic [3:0]                 cfg_interlaced,
  input  logic [1:0]                 cfg_pattern,
  input  logic                       dout_ready,
  output logic                       dout_valid,
  output logic                       dout_sop,
  output logic                       dout_eop,
  output logic [BITS_PER_SYMBOL-1:0] dout_data,
  output logic                       busy,
  output logic [7:0]                 frame_count
);

  state_e                     state_q, state_d;
  logic [3:0]                 nib_idx_q, nib_idx_d;
  logic [15:0]                x_q, x_d;
  logic [15:0]                y_q, y_d;
  logic [15:0]                width_q, width_d;
  logic [15:0]                height_q, height_d;
  logic [3:0]                 interlaced_q, interlaced_d;
  logic [1:0]                 pattern_q, pattern_d;
  logic [7:0]                 frame_count_q, frame_count_d;
  logic                       busy_q, busy_d;
  logic                       valid_q, valid_d;
  logic                       sop_q, sop_d;
  logic                       eop_q, eop_d;
  logic [BITS_PER_SYMBOL-1:0] data_q, data_d;

  logic        cfg_legal;
  logic        xfer;
  logic        start_frame;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic        pix_last;
  logic        frame_last;
  logic [7:0]  pixel;

  assign cfg_legal  = (cfg_width != 16'd0) && (cfg_height != 16'd0);
  assign xfer       = valid_q & dout_ready;
  assign frame_last = (x_q == width_q - 16'd1) && (y_q == height_q - 16'd1);

  // Coordinates of the pixel that follows the beat currently on the output.
  always_comb begin
    pix_x = 16'd0;
    pix_y = 16'd0;
    if (state_q == VID_PIX) begin
      if (x_q == width_q - 16'd1) begin
        pix_y = y_q + 16'd1;
      end else begin
        pix_x = x_q + 16'd1;
        pix_y = y_q;
      end
    end
  end

  assign pix_last = (pix_x == width_q - 16'd1) && (pix_y == height_q - 16'd1);

  vip_pattern_pixel_gen #(
    .CHECKER_SHIFT(CHECKER_SHIFT)
  ) u_pixel_gen (
    .pattern    (pattern_q),
    .x          (pix_x),
    .y          (pix_y),
    .frame_count(frame_count_q),
    .pixel      (pixel)
  );

  // The state names the beat held in the output register; a new beat is
  // loaded only when the current one transfers, so stalls hold everything.
  always_comb begin
    state_d       = state_q;
    nib_idx_d     = nib_idx_q;
    x_d           = x_q;
    y_d           = y_q;
    width_d       = width_q;
    height_d      = height_q;
    interlaced_d  = interlaced_q;
    pattern_d     = pattern_q;
    frame_count_d = frame_count_q;
    busy_d        = busy_q;
    valid_d       = valid_q;
    sop_d         = sop_q;
    eop_d         = eop_q;
    data_d        = data_q;
    start_frame   = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && cfg_legal) begin
          start_frame = 1'b1;
        end
      end
      CTRL_HDR: begin
        if (xfer) begin
          state_d     = CTRL_NIB;
          nib_idx_d   = 4'd0;
          sop_d       = 1'b0;
          eop_d       = 1'b0;
          data_d      = '0;
          data_d[3:0] = ctrl_nibble(width_q, height_q, interlaced_q, 4'd0);
        end
      end
      CTRL_NIB: begin
        if (xfer) begin
          if (nib_idx_q == 4'd8) begin
            state_d     = VID_HDR;
            sop_d       = 1'b1;
            eop_d       = 1'b0;
            data_d      = '0;
            data_d[3:0] = PKT_VIDEO;
          end else begin
            nib_idx_d   = nib_idx_q + 4'd1;
            eop_d       = (nib_idx_q == 4'd7);
            data_d      = '0;
            data_d[3:0] = ctrl_nibble(width_q, height_q, interlaced_q, nib_idx_q + 4'd1);
          end
        end
      end
      VID_HDR: begin
        if (xfer) begin
          state_d     = VID_PIX;
          x_d         = pix_x;
          y_d         = pix_y;
          sop_d       = 1'b0;
          eop_d       = pix_last;
          data_d      = '0;
          data_d[7:0] = pixel;
        end
      end
      VID_PIX: begin
        if (xfer) begin
          if (frame_last) begin
            frame_count_d = frame_count_q + 8'd1;
            busy_d        = 1'b0;
            x_d           = 16'd0;
            y_d           = 16'd0;
            if (enable && cfg_legal) begin
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
              data_d  = '0;
            end
          end else begin
            x_d         = pix_x;
            y_d         = pix_y;
            eop_d       = pix_last;
            data_d      = '0;
            data_d[7:0] = pixel;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (start_frame) begin
      width_d      = cfg_width;
      height_d     = cfg_height;
      interlaced_d = cfg_interlaced;
      pattern_d    = cfg_pattern;
      busy_d       = 1'b1;
      state_d      = CTRL_HDR;
      valid_d      = 1'b1;
      sop_d        = 1'b1;
      eop_d        = 1'b0;
      data_d       = '0;
      data_d[3:0]  = PKT_CTRL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      nib_idx_q     <= 4'd0;
      x_q           <= 16'd0;
      y_q           <= 16'd0;
      width_q       <= 16'd0;
      height_q      <= 16'd0;
      interlaced_q  <= 4'd0;
      pattern_q     <= 2'd0;
      frame_count_q <= 8'd0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      nib_idx_q     <= nib_idx_d;
      x_q           <= x_d;
      y_q           <= y_d;
      width_q       <= width_d;
      height_q      <= height_d;
      interlaced_q  <= interlaced_d;
      pattern_q     <= pattern_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
      data_q        <= data_d;
    end
  end

  assign dout_valid  = valid_q;
  assign dout_sop    = sop_q;
  assign dout_eop    = eop_q;
  assign dout_data   = data_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vip_test_pattern_source.sv
// Directed bench for vip_test_pattern_source: expected beats are queued when a
// frame is requested and compared as the DUT transfers them.
module tb_vip_test_pattern_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] cfg_width = 16'd0;
  logic [15:0] cfg_height = 16'd0;
  logic [3:0]  cfg_interlaced = 4'd0;
  logic [1:0]  cfg_pattern = 2'd0;
  logic        dout_ready = 1'b1;
  logic        dout_valid;
  logic        dout_sop;
  logic        dout_eop;
  logic [7:0]  dout_data;
  logic        busy;
  logic [7:0]  frame_count;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];
  int    tests_run = 0;
  int    tests_failed = 0;
  bit    ready_mode = 1'b0;
  bit    ready_level = 1'b1;
  bit    holding = 1'b0;
  beat_t held;

  vip_test_pattern_source #(
    .BITS_PER_SYMBOL(8),
    .CHECKER_SHIFT  (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .cfg_interlaced(cfg_interlaced),
    .cfg_pattern   (cfg_pattern),
    .dout_ready    (dout_ready),
    .dout_valid    (dout_valid),
    .dout_sop      (dout_sop),
    .dout_eop      (dout_eop),
    .dout_data     (dout_data),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic beat_t make_beat(input bit sop, input bit eop, input int value);
    beat_t b;
    b.sop  = sop;
    b.eop  = eop;
    b.data = 8'(value);
    return b;
  endfunction

  function automatic int model_pixel(input int pat, input int x, input int y, input int fc);
    case (pat)
      0:       return x % 256;
      1:       return y % 256;
      2:       return (((x / 8) + (y / 8)) % 2 == 1) ? 255 : 0;
      default: return fc % 256;
    endcase
  endfunction

  // Queue one frame; max_pix lets a huge frame be checked only up to a point.
  task automatic push_frame(input int w, input int h, input int il, input int pat,
                            input int fc, input int max_pix);
    int cnt;
    int nib;
    sb.push_back(make_beat(1'b1, 1'b0, 15));
    for (int i = 0; i < 9; i++) begin
      if (i < 4)      nib = (w >> (12 - 4 * i)) % 16;
      else if (i < 8) nib = (h >> (12 - 4 * (i - 4))) % 16;
      else            nib = il;
      sb.push_back(make_beat(1'b0, i == 8, nib));
    end
    sb.push_back(make_beat(1'b1, 1'b0, 0));
    cnt = 0;
    for (int y = 0; y < h && cnt < max_pix; y++) begin
      for (int x = 0; x < w && cnt < max_pix; x++) begin
        sb.push_back(make_beat(1'b0, (x == w - 1) && (y == h - 1), model_pixel(pat, x, y, fc)));
        cnt++;
      end
    end
  endtask

  // Sampled on the falling edge: a beat seen with valid & ready here is the
  // one the next rising edge transfers.
  task automatic check_output();
    beat_t obs;
    beat_t exp_beat;
    if (rst) begin
      holding = 1'b0;
    end else if (dout_valid) begin
      obs = {dout_sop, dout_eop, dout_data};
      check_value("busy_while_valid", 32'(busy), 32'd1);
      if (holding) check_value("stall_stable", 32'(obs), 32'(held));
      if (dout_ready) begin
        holding = 1'b0;
        tests_run++;
        assert (sb.size() != 0) else begin
          tests_failed++;
          $error("[TB] FAIL unexpected_beat observed=%0h expected=none", obs);
        end
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          check_value("beat", 32'(obs), 32'(exp_beat));
        end
      end else begin
        holding = 1'b1;
        held    = obs;
      end
    end else begin
      check_value("valid_not_dropped", 32'(holding), 32'd0);
      holding = 1'b0;
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
    dout_ready = ready_mode ? ($urandom_range(0, 1) != 0) : ready_level;
    @(negedge clk);
    check_output();
  endtask

  task automatic apply_stimulus(input int w, input int h, input int il, input int pat,
                                input int fc, input bit hold_enable);
    cfg_width      = 16'(w);
    cfg_height     = 16'(h);
    cfg_interlaced = 4'(il);
    cfg_pattern    = 2'(pat);
    enable         = 1'b1;
    push_frame(w, h, il, pat, fc, w * h);
    if (!hold_enable) begin
      step_cycle();
      enable = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step_cycle();
      n++;
    end
    check_value(tag, 32'(sb.size()), 32'd0);
    step_cycle();
  endtask

  task automatic count_activity(input int cycles, input string tag);
    int act = 0;
    for (int i = 0; i < cycles; i++) begin
      step_cycle();
      if (dout_valid || busy) act++;
    end
    check_value(tag, 32'(act), 32'd0);
  endtask

  initial begin
    int n;
    step_cycle();
    step_cycle();
    check_value("rst_valid", 32'(dout_valid), 32'd0);
    check_value("rst_sop", 32'(dout_sop), 32'd0);
    check_value("rst_eop", 32'(dout_eop), 32'd0);
    check_value("rst_data", 32'(dout_data), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_frame_count", 32'(frame_count), 32'd0);
    rst = 1'b0;

    cfg_width  = 16'd0;
    cfg_height = 16'd4;
    enable     = 1'b1;
    count_activity(100, "illegal_geometry_idle");

    apply_stimulus(2, 1, 0, 0, 0, 1'b0);
    wait_drain(100, "frame_2x1_drain");
    check_value("frame_2x1_busy", 32'(busy), 32'd0);
    check_value("frame_2x1_count", 32'(frame_count), 32'd1);
    count_activity(5, "frame_2x1_no_restart");

    apply_stimulus(4, 2, 0, 0, 1, 1'b0);
    wait_drain(100, "frame_4x2_drain");
    check_value("frame_4x2_busy", 32'(busy), 32'd0);
    check_value("frame_4x2_count", 32'(frame_count), 32'd2);

    ready_mode = 1'b1;
    apply_stimulus(4, 2, 0, 0, 2, 1'b0);
    wait_drain(400, "frame_4x2_stall_drain");
    check_value("frame_4x2_stall_count", 32'(frame_count), 32'd3);

    apply_stimulus(16, 16, 5, 2, 3, 1'b0);
    wait_drain(3000, "checker_drain");
    check_value("checker_count", 32'(frame_count), 32'd4);
    ready_mode = 1'b0;

    apply_stimulus(8, 8, 0, 1, 4, 1'b1);
    n = 0;
    while (sb.size() > 62 && n < 200) begin
      step_cycle();
      n++;
    end
    check_value("enable_drop_reached_pixel3", 32'(sb.size() <= 62), 32'd1);
    enable = 1'b0;
    wait_drain(200, "enable_drop_drain");
    check_value("enable_drop_count", 32'(frame_count), 32'd5);
    count_activity(30, "enable_drop_idle");

    cfg_width      = 16'd640;
    cfg_height     = 16'd480;
    cfg_interlaced = 4'h3;
    cfg_pattern    = 2'd0;
    enable         = 1'b1;
    push_frame(640, 480, 3, 0, 5, 20);
    step_cycle();
    enable = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step_cycle();
      n++;
    end
    check_value("ctrl_640x480_prefix", 32'(sb.size()), 32'd0);
    ready_level = 1'b0;
    step_cycle();
    step_cycle();
    step_cycle();
    check_value("midframe_valid_before_rst", 32'(dout_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_value("midframe_rst_valid", 32'(dout_valid), 32'd0);
    check_value("midframe_rst_busy", 32'(busy), 32'd0);
    check_value("midframe_rst_frame_count", 32'(frame_count), 32'd0);
    sb.delete();
    step_cycle();
    rst         = 1'b0;
    ready_level = 1'b1;

    cfg_width      = 16'd1;
    cfg_height     = 16'd1;
    cfg_interlaced = 4'd0;
    cfg_pattern    = 2'd3;
    enable         = 1'b1;
    for (int f = 0; f < 257; f++) push_frame(1, 1, 0, 3, f, 1);
    n = 0;
    while (sb.size() >= 12 && n < 5000) begin
      step_cycle();
      n++;
    end
    check_value("flat_reached_last_frame", 32'(sb.size() < 12), 32'd1);
    enable = 1'b0;
    wait_drain(100, "flat_drain");
    check_value("flat_frame_count_wrap", 32'(frame_count), 32'd1);
    count_activity(10, "flat_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
